// File: rtl/noc_input_vc_buffer_pkg.sv
// Shared types for the router input buffer.
//   noc_config         : network configuration (VC count, input FIFO depth)
//   NOC_DEFAULT_CONFIG : 2 virtual channels, 4-entry input FIFOs
//   noc_flit_t         : flit carried on every router link
package noc_input_vc_buffer_pkg;

  typedef struct packed {
    int unsigned virtual_channels;
    int unsigned input_fifo_depth;
  } noc_config;

  localparam noc_config NOC_DEFAULT_CONFIG = '{virtual_channels: 2, input_fifo_depth: 4};

  localparam int FLIT_DATA_W = 32;

  typedef struct packed {
    logic                   head;
    logic                   tail;
    logic [FLIT_DATA_W-1:0] data;
  } noc_flit_t;

endpackage

// File: rtl/noc_input_vc_buffer_if.sv
// Router link interface carrying one shared flit and per-VC handshakes.
//   flit         : flit bus, shared by all VCs of the link
//   valid        : per-VC valid, one-hot or zero (initiator -> target)
//   ready        : per-VC accept (target -> initiator)
//   vc_available : per-VC early back-pressure (target -> initiator)
// Modports: initiator (master side, sends flits), target (slave side, receives).
interface noc_flit_if
  import noc_input_vc_buffer_pkg::*;
#(
  parameter noc_config CONFIG   = NOC_DEFAULT_CONFIG,
  parameter int        CHANNELS = CONFIG.virtual_channels
);
  noc_flit_t           flit;
  logic [CHANNELS-1:0] valid;
  logic [CHANNELS-1:0] ready;
  logic [CHANNELS-1:0] vc_available;

  modport initiator (
    output flit,
    output valid,
    input  ready,
    input  vc_available
  );

  modport target (
    input  flit,
    input  valid,
    output ready,
    output vc_available
  );
endinterface

// File: rtl/noc_input_vc_buffer_vc_fifo.sv
// noc_vc_fifo: single virtual-channel FIFO of the router input buffer.
// Optional feature macro: NOC_INPUT_BUFFER_BYPASS_EN (empty-FIFO cut-through).
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   push_valid    : upstream offers a flit for this VC
//   push_flit     : upstream flit (shared link bus)
//   push_ready    : FIFO not full
//   vc_available  : registered, at least two free entries after this update
//   pop_valid     : head flit present for the route selector
//   pop_flit      : head flit, '0 when nothing is presented
//   pop_ready     : route selector takes the head flit
module noc_vc_fifo
  import noc_input_vc_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_valid,
  input  noc_flit_t push_flit,
  output logic      push_ready,
  output logic      vc_available,
  output logic      pop_valid,
  output noc_flit_t pop_flit,
  input  logic      pop_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  noc_flit_t       mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic            empty;
  logic            push;
  logic            write;
  logic            read;

  assign empty = (count == '0);

  // ready depends on the registered count only, so a full FIFO refuses a
  // push even when the route selector pops in the same cycle.
  assign push_ready = (count != CW'(DEPTH));
  assign push       = push_valid && push_ready;

`ifdef NOC_INPUT_BUFFER_BYPASS_EN
  // Empty FIFO: present the incoming flit directly; if it is taken in the
  // same cycle it never touches the memory.
  assign pop_valid = !empty || push_valid;

  always_comb begin
    pop_flit = '0;
    if (!empty)
      pop_flit = mem[rptr];
    else if (push_valid)
      pop_flit = push_flit;
  end

  assign write = push && !(empty && pop_ready);
`else
  assign pop_valid = !empty;
  assign pop_flit  = empty ? '0 : mem[rptr];
  assign write     = push;
`endif

  // Only a non-empty FIFO advances its read side.
  assign read = pop_valid && pop_ready && !empty;

  always_comb begin
    count_next = count;
    if (write && !read)
      count_next = count + 1'b1;
    else if (!write && read)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      vc_available <= 1'b1;
    end else begin
      if (write)
        wptr <= wptr + 1'b1;
      if (read)
        rptr <= rptr + 1'b1;
      count        <= count_next;
      // Drops one flit early so upstream stops before ready does.
      vc_available <= (count_next <= CW'(DEPTH - 2));
    end
  end

  // Storage is never reset; valid is qualified by count.
  always_ff @(posedge clk) begin
    if (write)
      mem[wptr] <= push_flit;
  end

endmodule

// File: rtl/noc_input_vc_buffer.sv
// noc_input_vc_buffer: per-port router input buffer, one FIFO per VC.
// Optional feature macro: NOC_INPUT_BUFFER_BYPASS_EN (0-cycle latency when
// a VC is empty; otherwise latency is always one cycle).
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   flit_in_if         : link input (target); drives ready / vc_available
//   flit_out_if[VC]    : one initiator per VC toward the route selector;
//                        its vc_available input is not used
// Parameters: CONFIG (network configuration), DEPTH (entries per VC,
// power of two, >= 2).
module noc_input_vc_buffer
  import noc_input_vc_buffer_pkg::*;
#(
  parameter noc_config CONFIG = NOC_DEFAULT_CONFIG,
  parameter int        DEPTH  = CONFIG.input_fifo_depth
) (
  input  logic          clk,
  input  logic          rst_n,
  noc_flit_if.target    flit_in_if,
  noc_flit_if.initiator flit_out_if [CONFIG.virtual_channels]
);
  localparam int CHANNELS = CONFIG.virtual_channels;

  logic [CHANNELS-1:0] ready_vec;
  logic [CHANNELS-1:0] vc_available_vec;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_vc
    noc_vc_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_valid   (flit_in_if.valid[i]),
      .push_flit    (flit_in_if.flit),
      .push_ready   (ready_vec[i]),
      .vc_available (vc_available_vec[i]),
      .pop_valid    (flit_out_if[i].valid[0]),
      .pop_flit     (flit_out_if[i].flit),
      .pop_ready    (flit_out_if[i].ready[0])
    );
  end

  assign flit_in_if.ready        = ready_vec;
  assign flit_in_if.vc_available = vc_available_vec;

  // Upstream may offer a flit on at most one VC per cycle.
  a_valid_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(flit_in_if.valid));

endmodule

// File: tb/tb_noc_input_vc_buffer.sv
// Directed testbench for noc_input_vc_buffer (2 VCs, DEPTH 4).
module tb_noc_input_vc_buffer;
  import noc_input_vc_buffer_pkg::*;

`ifdef NOC_INPUT_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  noc_flit_if #(.CONFIG(NOC_DEFAULT_CONFIG), .CHANNELS(2)) in_if ();
  noc_flit_if #(.CONFIG(NOC_DEFAULT_CONFIG), .CHANNELS(1)) out_if [2] ();

  logic [1:0] out_ready;
  logic [1:0] out_valid;
  noc_flit_t  out_flit [2];

  for (genvar g = 0; g < 2; g++) begin : g_out
    assign out_if[g].ready        = out_ready[g];
    assign out_if[g].vc_available = 1'b0;
    assign out_valid[g]           = out_if[g].valid[0];
    assign out_flit[g]            = out_if[g].flit;
  end

  noc_input_vc_buffer #(.CONFIG(NOC_DEFAULT_CONFIG), .DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flit_in_if  (in_if),
    .flit_out_if (out_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  noc_flit_t q0 [$];
  noc_flit_t q1 [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic noc_flit_t mk(input int n);
    noc_flit_t f;
    f.head = 1'b0;
    f.tail = 1'b0;
    f.data = 32'hA000_0000 + n;
    return f;
  endfunction

  // Apply inputs just after a rising edge, return at the following falling edge.
  task automatic step(input logic [1:0] vld, input noc_flit_t f, input logic [1:0] ordy);
    @(posedge clk);
    #1;
    in_if.valid = vld;
    in_if.flit  = f;
    out_ready   = ordy;
    @(negedge clk);
  endtask

  task automatic observe();
    noc_flit_t e;
    for (int v = 0; v < 2; v++) begin
      if (out_valid[v] && out_ready[v]) begin
        if (v == 0 && q0.size() == 0) chk("stream_extra0", 1, 0);
        else if (v == 1 && q1.size() == 0) chk("stream_extra1", 1, 0);
        else begin
          e = (v == 0) ? q0.pop_front() : q1.pop_front();
          chk(v == 0 ? "stream_order0" : "stream_order1", out_flit[v], e);
        end
      end
    end
  endtask

  initial begin
    noc_flit_t f;
    int vc;
    rst_n       = 1'b0;
    in_if.valid = '0;
    in_if.flit  = '0;
    out_ready   = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_ready", in_if.ready, 2'b11);
    chk("rst_vcav", in_if.vc_available, 2'b11);
    chk("rst_valid", out_valid, 2'b00);
    chk("rst_flit0", out_flit[0], 0);
    chk("rst_flit1", out_flit[1], 0);

    // Fill VC0 with downstream stalled
    for (int n = 1; n <= 4; n++) begin
      step(2'b01, mk(n - 1), 2'b00);
      chk("fill_ready_pre", in_if.ready[0], 1'b1);
      step(2'b00, '0, 2'b00);
      chk("fill_ready0", in_if.ready[0], (n < 4));
      chk("fill_vcav0", in_if.vc_available[0], (n <= 2));
      chk("fill_ready1", in_if.ready[1], 1'b1);
      chk("fill_vcav1", in_if.vc_available[1], 1'b1);
      chk("fill_valid0", out_valid[0], 1'b1);
      chk("fill_head0", out_flit[0], mk(0));
      chk("fill_valid1", out_valid[1], 1'b0);
    end

    // Full VC0: push and pop together, push must be refused
    step(2'b01, mk(9), 2'b01);
    chk("full_ready0", in_if.ready[0], 1'b0);
    chk("full_head0", out_flit[0], mk(0));
    step(2'b00, '0, 2'b00);
    chk("full_pop_ready0", in_if.ready[0], 1'b1);
    chk("full_pop_vcav0", in_if.vc_available[0], 1'b0);
    for (int j = 1; j <= 3; j++) begin
      step(2'b00, '0, 2'b01);
      chk("drain_valid0", out_valid[0], 1'b1);
      chk("drain_flit0", out_flit[0], mk(j));
    end
    step(2'b00, '0, 2'b00);
    chk("drain_empty0", out_valid[0], 1'b0);
    chk("drain_flit_zero0", out_flit[0], 0);
    chk("drain_vcav0", in_if.vc_available[0], 1'b1);

    // Latency into an empty VC with downstream ready
    step(2'b01, mk(20), 2'b01);
    chk("lat_valid_n", out_valid[0], BYP);
    chk("lat_flit_n", out_flit[0], BYP ? mk(20) : noc_flit_t'('0));
    step(2'b00, '0, 2'b01);
    chk("lat_valid_n1", out_valid[0], !BYP);
    chk("lat_flit_n1", out_flit[0], BYP ? noc_flit_t'('0) : mk(20));
    step(2'b00, '0, 2'b00);
    chk("lat_empty", out_valid[0], 1'b0);
    chk("lat_ready0", in_if.ready[0], 1'b1);

    // Streaming, alternating VCs, downstream always ready
    for (int k = 0; k < 100; k++) begin
      vc = k % 2;
      f  = mk(100 + k);
      if (vc == 0) q0.push_back(f);
      else         q1.push_back(f);
      step(vc == 0 ? 2'b01 : 2'b10, f, 2'b11);
      chk("stream_ready", in_if.ready[vc], 1'b1);
      chk("stream_vcav", in_if.vc_available[vc], 1'b1);
      observe();
    end
    for (int k = 0; k < 3; k++) begin
      step(2'b00, '0, 2'b11);
      observe();
    end
    chk("stream_left0", q0.size(), 0);
    chk("stream_left1", q1.size(), 0);
    chk("stream_idle", out_valid, 2'b00);

    // Mid-stream asynchronous reset with VC1 holding three flits
    for (int j = 0; j < 3; j++) step(2'b10, mk(300 + j), 2'b00);
    step(2'b00, '0, 2'b00);
    chk("pre_rst_valid1", out_valid[1], 1'b1);
    chk("pre_rst_vcav1", in_if.vc_available[1], 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid1", out_valid[1], 1'b0);
    chk("arst_flit1", out_flit[1], 0);
    chk("arst_ready1", in_if.ready[1], 1'b1);
    chk("arst_vcav1", in_if.vc_available[1], 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step(2'b10, mk(400 + j), 2'b00);
      chk("post_rst_ready1", in_if.ready[1], 1'b1);
    end
    step(2'b00, '0, 2'b00);
    chk("post_rst_full1", in_if.ready[1], 1'b0);
    for (int j = 0; j < 4; j++) begin
      step(2'b00, '0, 2'b10);
      chk("post_rst_flit1", out_flit[1], mk(400 + j));
    end
    step(2'b00, '0, 2'b00);
    chk("post_rst_empty1", out_valid[1], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
